// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with a valid/ready request and result handshake.
// Ports: clk, rst_n, InValid/InReady, ALUCtrl, OpA, OpB,
//   OutValid/OutReady, Result, Zero, Overflow, IllegalOp.
// Option: define ALU_FAST_SHIFT_EN for single-cycle barrel shifts.
module alu_exec_unit #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             IllegalOp
);

`ifdef ALU_FAST_SHIFT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
`endif

  state_t state, state_n;

  logic [WIDTH-1:0] res, res_n;
  logic zero, zero_n;
  logic ovf, ovf_n;
  logic ill, ill_n;

`ifndef ALU_FAST_SHIFT_EN
  logic [SHAMT_W-1:0] cnt, cnt_n;
  logic               sra_q, sra_n;
`endif

  logic [SHAMT_W-1:0] amt;
  logic [WIDTH-1:0]   sum, diff;
  logic               add_ov, sub_ov;
  logic op_and, op_or, op_xor, op_add;
  logic op_sub, op_slt, op_sll, op_sra;

  localparam int MSB = WIDTH - 1;

  assign amt  = OpB[SHAMT_W-1:0];
  assign sum  = OpA + OpB;
  assign diff = OpA - OpB;

  assign add_ov = (OpA[MSB] == OpB[MSB]) &&
                  (sum[MSB] != OpA[MSB]);
  // The negated operand's sign is taken from ~OpB so that
  // subtracting the most negative value still flags overflow.
  assign sub_ov = (OpA[MSB] == ~OpB[MSB]) &&
                  (diff[MSB] != OpA[MSB]);

  assign op_and = (ALUCtrl == 4'b0000);
  assign op_slt = (ALUCtrl == 4'b0001);
  assign op_or  = (ALUCtrl == 4'b0010);
  assign op_xor = (ALUCtrl == 4'b0011);
  assign op_add = (ALUCtrl[3:1] == 3'b010);
  assign op_sll = (ALUCtrl == 4'b0110);
  assign op_sra = (ALUCtrl == 4'b0111);
  assign op_sub = (ALUCtrl[3:1] == 3'b110);

  always_comb begin
    state_n = state;
    res_n   = res;
    zero_n  = zero;
    ovf_n   = ovf;
    ill_n   = ill;
`ifndef ALU_FAST_SHIFT_EN
    cnt_n   = cnt;
    sra_n   = sra_q;
`endif
    unique case (state)
      IDLE: begin
        if (InValid) begin
          state_n = DONE;
          ovf_n   = 1'b0;
          ill_n   = 1'b0;
          unique case (1'b1)
            op_and: res_n = OpA & OpB;
            op_or:  res_n = OpA | OpB;
            op_xor: res_n = OpA ^ OpB;
            op_add: begin
              res_n = sum;
              ovf_n = add_ov;
            end
            op_sub: begin
              res_n = diff;
              ovf_n = sub_ov;
            end
            op_slt: res_n = {{(WIDTH-1){1'b0}},
                             diff[MSB] ^ sub_ov};
            op_sll, op_sra: begin
`ifdef ALU_FAST_SHIFT_EN
              if (op_sra)
                res_n = WIDTH'($signed(OpA) >>> amt);
              else
                res_n = OpA << amt;
`else
              res_n = OpA;
              cnt_n = amt;
              sra_n = op_sra;
              if (amt != '0) state_n = SHIFT;
`endif
            end
            default: begin
              res_n = '0;
              ill_n = 1'b1;
            end
          endcase
          zero_n = (res_n == '0);
        end
      end
`ifndef ALU_FAST_SHIFT_EN
      SHIFT: begin
        if (sra_q)
          res_n = {res[MSB], res[MSB:1]};
        else
          res_n = {res[MSB-1:0], 1'b0};
        cnt_n  = cnt - SHAMT_W'(1);
        zero_n = (res_n == '0);
        if (cnt == SHAMT_W'(1)) state_n = DONE;
      end
`endif
      DONE: begin
        if (OutReady) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      res   <= '0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
      ill   <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      cnt   <= '0;
      sra_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      res   <= res_n;
      zero  <= zero_n;
      ovf   <= ovf_n;
      ill   <= ill_n;
`ifndef ALU_FAST_SHIFT_EN
      cnt   <= cnt_n;
      sra_q <= sra_n;
`endif
    end
  end

  assign InReady   = rst_n & (state == IDLE);
  assign OutValid  = (state == DONE);
  assign Result    = res;
  assign Zero      = zero;
  assign Overflow  = ovf;
  assign IllegalOp = ill;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed self-checking bench for alu_exec_unit.
// Hand-computed vectors for ops, flags, latency, backpressure, reset.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        InValid;
  logic        InReady;
  logic [3:0]  ALUCtrl;
  logic [15:0] OpA;
  logic [15:0] OpB;
  logic        OutValid;
  logic        OutReady;
  logic [15:0] Result;
  logic        Zero;
  logic        Overflow;
  logic        IllegalOp;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .InValid  (InValid),
    .InReady  (InReady),
    .ALUCtrl  (ALUCtrl),
    .OpA      (OpA),
    .OpB      (OpB),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Result   (Result),
    .Zero     (Zero),
    .Overflow (Overflow),
    .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] c,
                       input logic [15:0] a,
                       input logic [15:0] b);
    @(negedge clk);
    ALUCtrl = c;
    OpA     = a;
    OpB     = b;
    InValid = 1'b1;
    @(posedge clk);
    #1;
    InValid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!OutValid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!OutValid) check("timeout", 0, 1);
  endtask

  task automatic drain();
    OutReady = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag,
                     input logic [3:0] c,
                     input logic [15:0] a,
                     input logic [15:0] b,
                     input logic [15:0] er,
                     input logic ez,
                     input logic eo,
                     input logic ei,
                     input int elat);
    int lat;
    issue(c, a, b);
    wait_done(lat);
    check({tag, ".res"}, 32'(Result), 32'(er));
    check({tag, ".zero"}, 32'(Zero), 32'(ez));
    check({tag, ".ovf"}, 32'(Overflow), 32'(eo));
    check({tag, ".ill"}, 32'(IllegalOp), 32'(ei));
    check({tag, ".lat"}, 32'(lat), 32'(elat));
    drain();
  endtask

  int shl;

  initial begin
`ifdef ALU_FAST_SHIFT_EN
    shl = 0;
`else
    shl = 1;
`endif
    rst_n    = 1'b0;
    InValid  = 1'b0;
    OutReady = 1'b1;
    ALUCtrl  = 4'h0;
    OpA      = 16'h0;
    OpB      = 16'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst.ovalid", 32'(OutValid), 0);
    check("rst.res", 32'(Result), 0);
    check("rst.zero", 32'(Zero), 0);
    check("rst.ovf", 32'(Overflow), 0);
    check("rst.ill", 32'(IllegalOp), 0);
    check("rst.iready", 32'(InReady), 1);

    run("add_ovf", 4'b0100, 16'h7FFF, 16'h0001,
        16'h8000, 0, 1, 0, 1);
    run("add5", 4'b0101, 16'h1234, 16'h1111,
        16'h2345, 0, 0, 0, 1);
    run("sub_zero", 4'b1101, 16'h0005, 16'h0005,
        16'h0000, 1, 0, 0, 1);
    run("sub_ovf", 4'b1100, 16'h8000, 16'h0001,
        16'h7FFF, 0, 1, 0, 1);
    run("slt_neg", 4'b0001, 16'h8000, 16'h0001,
        16'h0001, 0, 0, 0, 1);
    run("slt_pos", 4'b0001, 16'h0001, 16'h8000,
        16'h0000, 1, 0, 0, 1);
    run("and", 4'b0000, 16'hF0F0, 16'hFF00,
        16'hF000, 0, 0, 0, 1);
    run("or", 4'b0010, 16'h0F00, 16'h00F0,
        16'h0FF0, 0, 0, 0, 1);
    run("xor", 4'b0011, 16'hFFFF, 16'h00FF,
        16'hFF00, 0, 0, 0, 1);
    run("sll15", 4'b0110, 16'h0001, 16'h000F,
        16'h8000, 0, 0, 0, 1 + 15 * shl);
    run("sra3", 4'b0111, 16'h8000, 16'h0003,
        16'hF000, 0, 0, 0, 1 + 3 * shl);
    run("sra0", 4'b0111, 16'h8000, 16'h0000,
        16'h8000, 0, 0, 0, 1);
    run("sll_out", 4'b0110, 16'h0100, 16'h0008,
        16'h0000, 1, 0, 0, 1 + 8 * shl);
    run("add_ovf2", 4'b0100, 16'h7FFF, 16'h0001,
        16'h8000, 0, 1, 0, 1);
    run("illegal", 4'b1111, 16'h1234, 16'h5678,
        16'h0000, 1, 0, 1, 1);

    OutReady = 1'b0;
    begin
      int lat;
      issue(4'b0100, 16'h0002, 16'h0003);
      wait_done(lat);
      check("bp.lat", 32'(lat), 1);
      for (int i = 0; i < 5; i++) begin
        @(posedge clk);
        #1;
        check("bp.ovalid", 32'(OutValid), 1);
        check("bp.res", 32'(Result), 32'h5);
        check("bp.iready", 32'(InReady), 0);
      end
      drain();
      check("bp.release", 32'(OutValid), 0);
      check("bp.iready2", 32'(InReady), 1);
    end

    issue(4'b0110, 16'h0001, 16'h000A);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mrst.ovalid", 32'(OutValid), 0);
    check("mrst.res", 32'(Result), 0);
    check("mrst.zero", 32'(Zero), 0);
    check("mrst.ovf", 32'(Overflow), 0);
    check("mrst.ill", 32'(IllegalOp), 0);
    check("mrst.iready", 32'(InReady), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mrst.iready2", 32'(InReady), 1);
    run("post_rst", 4'b0100, 16'h0100, 16'h0023,
        16'h0123, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
